// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared
//            ALU. Define MDU_ABORT_EN to add the optional abort input.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int WIDTH_SZ = 32,
    parameter int OP_SZ    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef MDU_ABORT_EN
    input  logic                abort,
`endif
    input  logic [1:0]          op,
    input  logic [WIDTH_SZ-1:0] rs_val,
    input  logic [WIDTH_SZ-1:0] rt_val,
    output logic [WIDTH_SZ-1:0] alu_a,
    output logic [WIDTH_SZ-1:0] alu_b,
    output logic [OP_SZ-1:0]    alu_sel,
    input  logic [WIDTH_SZ-1:0] alu_out,
    output logic                busy,
    output logic                done,
    output logic [WIDTH_SZ-1:0] hi,
    output logic [WIDTH_SZ-1:0] lo
);

    localparam int                   c_CNT_W    = $clog2(WIDTH_SZ);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(WIDTH_SZ - 1);
    localparam logic [OP_SZ-1:0]     c_ALU_ADD  = OP_SZ'(0);
    localparam logic [OP_SZ-1:0]     c_ALU_SUB  = OP_SZ'(2);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_NEG_A  = 3'd1;
    localparam logic [2:0] c_NEG_B  = 3'd2;
    localparam logic [2:0] c_ITER   = 3'd3;
    localparam logic [2:0] c_FIX_LO = 3'd4;
    localparam logic [2:0] c_FIX_HI = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    logic [2:0]          r_state, w_next;
    logic [WIDTH_SZ-1:0] r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_is_div, r_signed, r_sa, r_sb, r_lo_zero;
    logic                w_accept, w_abort, w_div0;
    logic                w_neg_on_opnd, w_msb, w_sub_ok, w_carry;
    logic                w_neg_prod, w_fix_hi;
    logic [WIDTH_SZ-1:0] w_neg_src, w_rem_sh;

    assign busy     = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done     = (r_state == c_DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign w_accept = start && !busy;
    assign w_div0   = op[0] && (rt_val == '0);

`ifdef MDU_ABORT_EN
    assign w_abort = abort && busy;
`else
    assign w_abort = 1'b0;
`endif

    // Multiply keeps rs in r_opnd and rt in r_acc_lo; divide is the reverse.
    assign w_neg_on_opnd = (r_state == c_NEG_A) ^ r_is_div;
    assign w_neg_src     = w_neg_on_opnd ? r_opnd : r_acc_lo;

    assign w_rem_sh   = {r_acc_hi[WIDTH_SZ-2:0], r_acc_lo[WIDTH_SZ-1]};
    assign w_msb      = r_acc_hi[WIDTH_SZ-1];
    assign w_sub_ok   = w_msb || (w_rem_sh >= r_opnd);
    assign w_carry    = (alu_out < r_acc_hi);
    assign w_neg_prod = r_sa ^ r_sb;
    assign w_fix_hi   = r_is_div ? r_sa : w_neg_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = c_ALU_ADD;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (!w_accept)   w_next = c_IDLE;
                else if (w_div0) w_next = c_FIX_HI;
                else if (op[1])  w_next = c_NEG_A;
                else             w_next = c_ITER;
            end
            c_NEG_A, c_NEG_B: begin
                alu_sel = c_ALU_SUB;
                alu_b   = w_neg_src;
                w_next  = (r_state == c_NEG_A) ? c_NEG_B : c_ITER;
            end
            c_ITER: begin
                alu_b = r_opnd;
                if (r_is_div) begin
                    alu_a   = w_rem_sh;
                    alu_sel = c_ALU_SUB;
                end else begin
                    alu_a   = r_acc_hi;
                end
                if (r_cnt == c_CNT_LAST) w_next = r_signed ? c_FIX_LO : c_DONE;
            end
            c_FIX_LO: begin
                if (w_neg_prod) begin
                    alu_sel = c_ALU_SUB;
                    alu_b   = r_acc_lo;
                end
                w_next = c_FIX_HI;
            end
            c_FIX_HI: begin
                // 64-bit negate: high word is ~hi plus the borrow from a zero low word.
                if (w_fix_hi) begin
                    if (r_is_div) begin
                        alu_sel = c_ALU_SUB;
                        alu_b   = r_acc_hi;
                    end else begin
                        alu_a   = ~r_acc_hi;
                        alu_b   = WIDTH_SZ'(r_lo_zero);
                    end
                end
                w_next = c_DONE;
            end
            default: w_next = c_IDLE;
        endcase
        if (w_abort) w_next = c_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_signed  <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_lo_zero <= 1'b0;
        end else begin
            if (r_state == c_DONE) begin
                r_hi <= r_acc_hi;
                r_lo <= r_acc_lo;
            end
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_is_div  <= op[0];
                        r_signed  <= op[1];
                        r_sa      <= 1'b0;
                        r_sb      <= 1'b0;
                        r_lo_zero <= 1'b0;
                        r_cnt     <= '0;
                        if (op[0]) begin
                            // Divide by zero preloads the architectural result and skips ITER.
                            r_acc_hi <= w_div0 ? rs_val : '0;
                            r_acc_lo <= w_div0 ? '1 : rs_val;
                            r_opnd   <= rt_val;
                        end else begin
                            r_acc_hi <= '0;
                            r_acc_lo <= rt_val;
                            r_opnd   <= rs_val;
                        end
                    end
                end
                c_NEG_A, c_NEG_B: begin
                    if (r_state == c_NEG_A) r_sa <= w_neg_src[WIDTH_SZ-1];
                    else                    r_sb <= w_neg_src[WIDTH_SZ-1];
                    if (w_neg_src[WIDTH_SZ-1]) begin
                        if (w_neg_on_opnd) r_opnd   <= alu_out;
                        else               r_acc_lo <= alu_out;
                    end
                end
                c_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc_hi <= w_sub_ok ? alu_out : w_rem_sh;
                        r_acc_lo <= {r_acc_lo[WIDTH_SZ-2:0], w_sub_ok};
                    end else if (r_acc_lo[0]) begin
                        r_acc_hi <= {w_carry, alu_out[WIDTH_SZ-1:1]};
                        r_acc_lo <= {alu_out[0], r_acc_lo[WIDTH_SZ-1:1]};
                    end else begin
                        r_acc_hi <= {1'b0, r_acc_hi[WIDTH_SZ-1:1]};
                        r_acc_lo <= {r_acc_hi[0], r_acc_lo[WIDTH_SZ-1:1]};
                    end
                end
                c_FIX_LO: begin
                    if (w_neg_prod) begin
                        r_acc_lo  <= alu_out;
                        r_lo_zero <= (r_acc_lo == '0);
                    end
                end
                c_FIX_HI: begin
                    if (w_fix_hi) r_acc_hi <= alu_out;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Brief    : Randomized self-checking bench for mdu_seq against an arithmetic
//            reference model; abort scenarios are built when MDU_ABORT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
`ifdef MDU_ABORT_EN
    logic         abort  = 1'b0;
`endif
    logic [1:0]   op     = '0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic [W-1:0] alu_a, alu_b, alu_out, hi, lo;
    logic [3:0]   alu_sel;
    logic         busy, done;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;

    // Model state: m_cnt is the cycle index of the current op (accept cycle = 0).
    int           m_cnt = 0;
    int           m_lat = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always #5 clk = ~clk;

    assign alu_out = (alu_sel == 4'd0) ? alu_a + alu_b :
                     (alu_sel == 4'd2) ? alu_a - alu_b : '0;

    mdu_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef MDU_ABORT_EN
        .abort   (abort),
`endif
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] h, output logic [W-1:0] l, output int lat);
        logic [63:0] up;
        longint      p, q, r;
        lat = o[1] ? 37 : 33;
        h   = '0;
        l   = '0;
        if (o[0] && b == '0) begin
            h   = a;
            l   = '1;
            lat = 2;
        end else begin
            case (o)
                2'd0: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
                2'd1: begin l = a / b; h = a % b; end
                2'd2: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    h = p[63:32];
                    l = p[31:0];
                end
                default: begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    h = r[31:0];
                    l = q[31:0];
                end
            endcase
        end
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Single compare process: checks outputs, then predicts the next cycle.
    always @(negedge clk) begin
        logic eb, ed, ab;
        if (!rst_n) begin
            m_cnt = 0;
            m_hi  = '0;
            m_lo  = '0;
        end
        eb = (m_cnt > 0) && (m_cnt < m_lat);
        ed = (m_cnt > 0) && (m_cnt == m_lat);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (!eb) begin
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
            chk("alu_sel_idle", alu_sel, 0);
        end
        if (done) n_done++;
`ifdef MDU_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        if (rst_n) begin
            if (ed) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            if (start && !eb) begin
                ref_model(op, rs_val, rt_val, p_hi, p_lo, m_lat);
                m_cnt = 1;
            end else if (eb) begin
                m_cnt = ab ? 0 : m_cnt + 1;
            end else begin
                m_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int i = 0;
        while (busy && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (busy) chk("idle_wait_timeout", busy, 0);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
    endtask

    // n = cycle index of the done cycle, the accept cycle being 0.
    task automatic wait_done(input int inject_at, output int n);
        @(posedge clk);
        n = 1;
        #1;
        start  = 1'b0;
`ifdef MDU_ABORT_EN
        abort  = 1'b0;
`endif
        rs_val = $urandom;
        rt_val = $urandom;
        while (!done && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == inject_at);
            if (start) begin
                op     = 2'($urandom_range(0, 3));
                rs_val = $urandom;
                rt_val = $urandom;
            end
        end
        start = 1'b0;
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic run_lit(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        issue(o, a, b);
        wait_done(-1, n);
        chk({nm, "_latency"}, n, lat);
        @(posedge clk); #1;
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    task automatic run_to_cycle(input int c);
        int n;
        @(posedge clk);
        n = 1;
        #1;
        start = 1'b0;
        while (n < c) begin
            @(posedge clk); n++; #1;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_lit("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        run_lit("mult_neg",  2'd2, 32'hFFFF_FFFD, 32'd7,         37, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_lit("divu",      2'd1, 32'd100,       32'd7,         33, 32'd2,         32'd14);
        run_lit("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2,         37, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_lit("divu_zero", 2'd1, 32'd5,         32'd0,         2,  32'd5,         32'hFFFF_FFFF);
        run_lit("div_zero",  2'd3, 32'hFFFF_FFF7, 32'd0,         2,  32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run_lit("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 37, 32'd0,         32'h8000_0000);

        // Second start during a MULTU must be ignored.
        issue(2'd0, 32'd1000, 32'd3000);
        n_done = 0;
        wait_done(10, n);
        chk("ignored_start_latency", n, 33);
        repeat (40) @(posedge clk);
        #1;
        chk("ignored_start_one_done", n_done, 1);
        chk("ignored_start_hi", hi, 32'd0);
        chk("ignored_start_lo", lo, 32'h002D_C6C0);

        // Back-to-back: new start issued in the done cycle.
        issue(2'd1, 32'd100, 32'd7);
        wait_done(-1, n);
        issue(2'd2, 32'hFFFF_FFFD, 32'd7);
        wait_done(-1, n);
        chk("b2b_latency", n, 37);
        chk("b2b_first_lo", lo, 32'd14);
        chk("b2b_first_hi", hi, 32'd2);
        @(posedge clk); #1;
        chk("b2b_second_hi", hi, 32'hFFFF_FFFF);
        chk("b2b_second_lo", lo, 32'hFFFF_FFEB);

        // Reset mid-DIV clears everything at once and yields no done.
        issue(2'd3, 32'hFFFF_FFF9, 32'd2);
        run_to_cycle(15);
        n_done = 0;
        rst_n  = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("reset_no_done", n_done, 0);
        run_lit("after_reset", 2'd1, 32'd100, 32'd7, 33, 32'd2, 32'd14);

`ifdef MDU_ABORT_EN
        run_lit("pre_abort", 2'd0, 32'd6, 32'd7, 33, 32'd0, 32'd42);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2);
        run_to_cycle(15);
        n_done = 0;
        abort  = 1'b1;
        @(posedge clk); #1;
        abort  = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, 0);
        chk("abort_hi_kept", hi, 32'd0);
        chk("abort_lo_kept", lo, 32'd42);
        // Start wins over a simultaneous abort while idle.
        issue(2'd0, 32'd5, 32'd9);
        abort = 1'b1;
        wait_done(-1, n);
        chk("abort_start_latency", n, 33);
        @(posedge clk); #1;
        chk("abort_start_lo", lo, 32'd45);
`endif

        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done(-1, n);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
